// File: rtl/keyfile_reader_snap.sv
// Peripheral-bus reader that snapshots the 64-bit keyfile and folds it into a 16-bit rotate/XOR checksum.
// Optional one-cycle completion interrupt is built only when KEYFILE_IRQ_EN is defined.
module keyfile_reader_snap #(
  parameter logic [14:0] BASE_ADDR = 15'h00C0,
  parameter int          DEC_WD    = 4
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic [63:0] key_data_in,
  output logic [15:0] per_dout
`ifdef KEYFILE_IRQ_EN
  ,
  output logic        key_irq
`endif
);

  localparam int IDX_W = DEC_WD - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W0,
    S_W1,
    S_W2,
    S_W3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] snap_q, snap_d;
  logic [15:0] csum_q, csum_d;
  logic        valid_q, valid_d;
  logic        locked_q, locked_d;
  logic        chg_q, chg_d;
`ifdef KEYFILE_IRQ_EN
  logic        irq_q, irq_d;
`endif

  logic             reg_sel;
  logic [IDX_W-1:0] reg_idx;
  logic             reg_wr;
  logic             reg_rd;
  logic             ctrl_wr;
  logic             load_req;
  logic             clr_req;
  logic             busy;
  logic [15:0]      cur_word;
  logic [15:0]      csum_step;
  logic [15:0]      status_val;
  logic [15:0]      rd_val;
  logic [15:0]      snap_word [4];
  logic             unused_din;

  // Word-addressed decode: upper address bits select the 16-byte window, low bits the register.
  assign reg_sel = per_en & (per_addr[13:IDX_W] == BASE_ADDR[14:DEC_WD]);
  assign reg_idx = per_addr[IDX_W-1:0];
  assign reg_wr  = reg_sel & (|per_we);
  assign reg_rd  = reg_sel & ~(|per_we);
  assign ctrl_wr = reg_wr & (reg_idx == '0);

  // CLR outranks LOAD in the same write; the lock blocks both.
  assign load_req = ctrl_wr & per_din[0] & ~per_din[2] & ~locked_q;
  assign clr_req  = ctrl_wr & per_din[2] & ~locked_q;

  assign busy       = (state_q != S_IDLE);
  assign unused_din = &{1'b0, per_din[15:3]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    assign snap_word[gi] = snap_q[63-16*gi -: 16];
  end

  always_comb begin
    cur_word = 16'h0000;
    case (state_q)
      S_W0:    cur_word = snap_word[0];
      S_W1:    cur_word = snap_word[1];
      S_W2:    cur_word = snap_word[2];
      S_W3:    cur_word = snap_word[3];
      default: cur_word = 16'h0000;
    endcase
  end

  assign csum_step = {csum_q[14:0], csum_q[15]} ^ cur_word;

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    csum_d   = csum_q;
    valid_d  = valid_q;
    locked_d = locked_q | (ctrl_wr & per_din[1]);
    chg_d    = (key_data_in != snap_q);
`ifdef KEYFILE_IRQ_EN
    irq_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          snap_d  = key_data_in;
          csum_d  = 16'h0000;
          valid_d = 1'b0;
          state_d = S_W0;
        end
      end
      S_W0: begin
        csum_d  = csum_step;
        state_d = S_W1;
      end
      S_W1: begin
        csum_d  = csum_step;
        state_d = S_W2;
      end
      S_W2: begin
        csum_d  = csum_step;
        state_d = S_W3;
      end
      S_W3: begin
        csum_d  = csum_step;
        valid_d = 1'b1;
        state_d = S_IDLE;
`ifdef KEYFILE_IRQ_EN
        irq_d   = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Clear aborts a capture in flight, including one about to complete.
    if (clr_req) begin
      snap_d  = 64'h0;
      csum_d  = 16'h0000;
      valid_d = 1'b0;
      state_d = S_IDLE;
`ifdef KEYFILE_IRQ_EN
      irq_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q  <= S_IDLE;
      snap_q   <= 64'h0;
      csum_q   <= 16'h0000;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      chg_q    <= 1'b0;
`ifdef KEYFILE_IRQ_EN
      irq_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      csum_q   <= csum_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      chg_q    <= chg_d;
`ifdef KEYFILE_IRQ_EN
      irq_q    <= irq_d;
`endif
    end
  end

  assign status_val = {12'h000, chg_q, locked_q, valid_q, busy};

  always_comb begin
    rd_val = 16'h0000;
    case (reg_idx)
      IDX_W'(1): rd_val = status_val;
      IDX_W'(2): rd_val = snap_word[0];
      IDX_W'(3): rd_val = snap_word[1];
      IDX_W'(4): rd_val = snap_word[2];
      IDX_W'(5): rd_val = snap_word[3];
      IDX_W'(6): rd_val = csum_q;
      default:   rd_val = 16'h0000;
    endcase
  end

  assign per_dout = reg_rd ? rd_val : 16'h0000;

`ifdef KEYFILE_IRQ_EN
  assign key_irq = irq_q;
`endif

endmodule

// File: tb/tb_keyfile_reader_snap.sv
// Directed-plus-random bench for keyfile_reader_snap against a word-level model of snapshot, checksum and status.
module tb_keyfile_reader_snap;

  logic        mclk = 1'b0;
  logic        puc_rst_n = 1'b0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = '0;
  logic [63:0] key_data_in = '0;
  logic [15:0] per_dout;

  int vectors = 0;
  int errors  = 0;
  int exp_irq = 0;

  logic [63:0] m_snap   = '0;
  logic [15:0] m_csum   = '0;
  logic        m_valid  = 1'b0;
  logic        m_locked = 1'b0;

  localparam logic [13:0] BASE_W = 14'h0060;

`ifdef KEYFILE_IRQ_EN
  logic key_irq;
  int   irq_cnt = 0;
  always @(posedge mclk) if (key_irq === 1'b1) irq_cnt <= irq_cnt + 1;

  keyfile_reader_snap dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .key_data_in(key_data_in), .per_dout(per_dout),
    .key_irq(key_irq)
  );
`else
  keyfile_reader_snap dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .key_data_in(key_data_in), .per_dout(per_dout)
  );
`endif

  always #5 mclk = ~mclk;

  function automatic logic [15:0] ref_csum(input logic [63:0] k);
    logic [15:0] c = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      c = {c[14:0], c[15]} ^ k[63-16*i -: 16];
    end
    return c;
  endfunction

  function automatic logic [15:0] ref_status(input logic busy);
    return {12'h000, (key_data_in != m_snap), m_locked, m_valid, busy};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [13:0] addr, output logic [15:0] d);
    per_addr = addr;
    per_we   = 2'b00;
    per_en   = 1'b1;
    #1;
    d = per_dout;
    per_en = 1'b0;
    @(negedge mclk);
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] off, input logic [15:0] exp);
    logic [15:0] d;
    rd(BASE_W + 14'(off >> 1), d);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [3:0] off, input logic [15:0] data);
    per_addr = BASE_W + 14'(off >> 1);
    per_din  = data;
    per_we   = 2'b11;
    per_en   = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    per_en  = 1'b0;
    per_we  = 2'b00;
    per_din = '0;
  endtask

  task automatic chk_snapshot(input string tag);
    logic [63:0] s;
    s = m_snap;
    chk_reg({tag, "_key0"}, 4'h4, s[63:48]);
    chk_reg({tag, "_key1"}, 4'h6, s[47:32]);
    chk_reg({tag, "_key2"}, 4'h8, s[31:16]);
    chk_reg({tag, "_key3"}, 4'hA, s[15:0]);
    chk_reg({tag, "_csum"}, 4'hC, m_csum);
  endtask

  task automatic chk_irq(input string tag);
`ifdef KEYFILE_IRQ_EN
    check(tag, 16'(irq_cnt), 16'(exp_irq));
`endif
  endtask

  task automatic load_and_wait(input logic [63:0] k);
    key_data_in = k;
    wr(4'h0, 16'h0001);
    repeat (5) @(negedge mclk);
    m_snap  = k;
    m_csum  = ref_csum(k);
    m_valid = 1'b1;
    exp_irq++;
  endtask

  initial begin
    logic [15:0] d;
    logic [63:0] k;

    // Reset state
    repeat (3) @(negedge mclk);
    chk_reg("status_in_reset", 4'h2, 16'h0000);
    puc_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) chk_reg($sformatf("rst_off%0d", 2 * i), 4'(2 * i), 16'h0000);
`ifdef KEYFILE_IRQ_EN
    check("rst_irq", {15'd0, key_irq}, 16'h0000);
`endif

    // Directed load with busy window and interrupt pulse
    key_data_in = 64'h0001_0002_0003_0004;
    @(negedge mclk);
    wr(4'h0, 16'h0001);
    for (int c = 0; c < 4; c++) begin
      rd(BASE_W + 14'd1, d);
      check($sformatf("busy_c%0d", c), d & 16'h0001, 16'h0001);
    end
`ifdef KEYFILE_IRQ_EN
    check("irq_pulse_hi", {15'd0, key_irq}, 16'h0001);
`endif
    m_snap = key_data_in; m_csum = ref_csum(key_data_in); m_valid = 1'b1; exp_irq++;
    rd(BASE_W + 14'd1, d);
    check("status_done", d, 16'h0002);
`ifdef KEYFILE_IRQ_EN
    check("irq_pulse_lo", {15'd0, key_irq}, 16'h0000);
`endif
    chk_reg("csum_const", 4'hC, 16'h0002);
    chk_snapshot("dir");
    chk_irq("dir_irqcnt");

    // Live key divergence
    key_data_in = 64'hFFFF_0002_0003_0004;
    @(negedge mclk);
    chk_reg("chg_status", 4'h2, ref_status(1'b0));
    chk_reg("chg_key0", 4'h4, 16'h0001);

    // Read-only writes ignored, reserved/CTRL/out-of-window reads zero
    wr(4'h4, 16'hBEEF);
    wr(4'hC, 16'h1234);
    wr(4'h2, 16'hFFFF);
    chk_snapshot("ro_wr");
    chk_reg("ctrl_reads0", 4'h0, 16'h0000);
    chk_reg("rsvd_reads0", 4'hE, 16'h0000);
    rd(14'h0070, d);
    check("unsel_reads0", d, 16'h0000);

    // Random captures
    for (int n = 0; n < 8; n++) begin
      k = {$urandom, $urandom};
      load_and_wait(k);
      chk_snapshot($sformatf("rnd%0d", n));
      chk_reg($sformatf("rnd%0d_status", n), 4'h2, ref_status(1'b0));
      chk_irq($sformatf("rnd%0d_irqcnt", n));
    end

    // CLR two cycles into a capture aborts it
    key_data_in = {$urandom, $urandom} | 64'h1;
    wr(4'h0, 16'h0001);
    @(negedge mclk);
    wr(4'h0, 16'h0004);
    m_snap = '0; m_csum = '0; m_valid = 1'b0;
    repeat (6) @(negedge mclk);
    chk_reg("abort_status", 4'h2, ref_status(1'b0));
    chk_snapshot("abort");
    chk_irq("abort_irqcnt");

    // CLR and LOAD together: CLR wins
    load_and_wait({$urandom, $urandom});
    key_data_in = {$urandom, $urandom} | 64'h2;
    wr(4'h0, 16'h0005);
    m_snap = '0; m_csum = '0; m_valid = 1'b0;
    repeat (6) @(negedge mclk);
    chk_reg("clrload_status", 4'h2, ref_status(1'b0));
    chk_snapshot("clrload");
    chk_irq("clrload_irqcnt");

    // LOAD while busy ignored; key changes after capture edge do not leak in
    k = {$urandom, $urandom};
    key_data_in = k;
    wr(4'h0, 16'h0001);
    key_data_in = ~k;
    wr(4'h0, 16'h0001);
    repeat (5) @(negedge mclk);
    m_snap = k; m_csum = ref_csum(k); m_valid = 1'b1; exp_irq++;
    chk_snapshot("busyload");
    chk_reg("busyload_status", 4'h2, ref_status(1'b0));
    chk_irq("busyload_irqcnt");

    // Reset mid-capture
    key_data_in = {$urandom, $urandom} | 64'h4;
    wr(4'h0, 16'h0001);
    @(negedge mclk);
    puc_rst_n = 1'b0;
    m_snap = '0; m_csum = '0; m_valid = 1'b0; m_locked = 1'b0;
    chk_reg("midrst_status", 4'h2, 16'h0000);
    puc_rst_n = 1'b1;
    chk_reg("postrst_status", 4'h2, 16'h0000);
    chk_snapshot("postrst");
    repeat (6) @(negedge mclk);
    chk_reg("postrst_status2", 4'h2, ref_status(1'b0));
    chk_irq("postrst_irqcnt");

    // LOCK during a capture lets it finish, then freezes the snapshot
    k = {$urandom, $urandom};
    key_data_in = k;
    wr(4'h0, 16'h0001);
    wr(4'h0, 16'h0002);
    m_locked = 1'b1;
    repeat (5) @(negedge mclk);
    m_snap = k; m_csum = ref_csum(k); m_valid = 1'b1; exp_irq++;
    chk_reg("lock_status", 4'h2, 16'h0006);
    chk_snapshot("lock");
    key_data_in = ~k;
    wr(4'h0, 16'h0005);
    repeat (6) @(negedge mclk);
    chk_reg("locked_load_status", 4'h2, ref_status(1'b0));
    chk_snapshot("locked_load");
    wr(4'h0, 16'h0004);
    repeat (2) @(negedge mclk);
    chk_reg("locked_clr_status", 4'h2, ref_status(1'b0));
    chk_snapshot("locked_clr");
    chk_irq("lock_irqcnt");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
